cla_decomposed_pipe: RTL and testbench
======================================

// Module: cla_decomposed_pipe
// PURPOSE
//  Parametrised, pipelined successor of the 4-bit decomposed carry-lookahead adder.
//  Nonlinear terms (bitwise AND generate, XOR-of-products carries) and linear terms (XOR propagate/sum)
//  stay in separate logic cones; a register boundary sits between them.
//  Adds WIDTH/GROUP parametrisation, carry-in, subtract mode, carry-out/overflow, a tag and a
//  2-stage valid/ready pipeline with backpressure. Sits between operand source and result sink.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits, >=1
//  GROUP  4  lookahead group width, 1..WIDTH; last group is partial when WIDTH%GROUP!=0
//  TAG_W  4  width of sideband tag carried alongside each operation, >=1
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        block accepts beat this cycle
//  in_a       in   WIDTH    operand A
//  in_b       in   WIDTH    operand B
//  in_cin     in   1        carry-in
//  in_sub     in   1        1: compute A-B (B inverted, cin forced 1; in_cin ignored)
//  in_tag     in   TAG_W    sideband, returned unchanged with result
//  out_valid  out  1        result valid
//  out_ready  in   1        sink accepts result
//  out_sum    out  WIDTH    sum/difference, modulo 2^WIDTH
//  out_cout   out  1        carry-out of MSB (for sub: 1 = no borrow)
//  out_ovf    out  1        signed overflow: carry into MSB XOR carry out of MSB
//  out_tag    out  TAG_W    tag of this result
// BEHAVIOUR
//  - Handshake: beat transfers when valid&ready on same edge. Valid never depends on ready.
//    Payload held stable while out_valid&!out_ready.
//  - S1 (on in accept): bb = in_sub ? ~in_b : in_b; c0 = in_sub | in_cin;
//    registers g=in_a&bb, p=in_a^bb, c0, tag, v1<=1.
//  - S2 (on S1->S2 move): per group, carry c[i+1] = g[i] ^ p[i]g[i-1] ^ ... ^ p[i..j]c_grp
//    (XOR-of-products; terms mutually exclusive so XOR==OR); group carry-out feeds next
//    group (ripple between groups). sum = p ^ c[WIDTH-1:0]; cout=c[WIDTH];
//    ovf=c[WIDTH-1]^c[WIDTH]. Registered to out_*, out_valid<=1.
//  - Latency: 2 cycles accept->out_valid with no stall. Throughput 1 beat/cycle.
//  - Stall: s2_adv = !out_valid | out_ready; s1_adv = !v1 | s2_adv; in_ready = s1_adv.
//    v1 clears when S1 moves to S2 and no new beat accepted; out_valid clears on
//    out_ready with no S1 beat moving. Simultaneous accept+drain: both occur, no bubble.
//  - in_ready combinationally depends on out_ready (no skid); documented, sink must not
//    loop out_ready from in_ready.
//  - Order preserved; no beat dropped or duplicated; max 2 beats in flight.
//  - Reset (rst_n=0, async): v1, out_valid, out_sum, out_cout, out_ovf, out_tag, all S1
//    regs -> 0. in_ready=1 after reset released (pipeline empty). Reset mid-operation
//    discards in-flight beats; no partial result emitted.
//  - WIDTH==1 or GROUP==WIDTH: single group, full lookahead; GROUP==1: pure ripple.
//  - in_* ignored when in_valid=0; X on ignored inputs must not reach outputs.
// TESTING
//  - WIDTH=8: a=0xFF,b=0x01,cin=0,sub=0 -> sum=0x00,cout=1,ovf=0, out_valid 2 cycles later.
//  - a=0x7F,b=0x01 add -> sum=0x80,cout=0,ovf=1; a=0x05,b=0x07,sub=1 -> sum=0xFE,cout=0,ovf=0.
//  - Backpressure: stream tags 0..5 back-to-back, out_ready=0 for 4 cycles mid-stream ->
//    in_ready drops after 2 held beats; results return in tag order 0..5, payload stable while stalled.
//  - Reset asserted with 2 beats in flight -> out_valid=0 immediately, no stale result after release.
//  - Random 10k vectors for (WIDTH,GROUP)=(8,4),(13,4),(16,1),(1,1), random valid/ready
//    -> sum/cout/ovf match {a+b+cin} / {a-b} model, exact count and order.

Source files
------------

// File: rtl/cla_decomposed_pipe.sv
// Pipelined carry-lookahead adder/subtractor: S1 registers generate/propagate, S2 resolves XOR-of-products carries.
// Latency 2 cycles accept->out_valid, one beat per cycle when unstalled.
// Backpressure: in_ready = !v1 | !out_valid | out_ready (combinational from out_ready, no skid buffer).
module cla_decomposed_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NG = (WIDTH + GROUP - 1) / GROUP;
  localparam int PW = NG * GROUP;

  logic             v1_q, v1_d;
  logic [WIDTH-1:0] g_q, g_d, p_q, p_d;
  logic             c0_q, c0_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  logic             ovld_q, ovld_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] bb;
  logic [PW-1:0]    gx, px;
  logic [PW:0]      c;
  logic             acc, prod, cg;

  assign s2_adv   = !ovld_q | out_ready;
  assign s1_adv   = !v1_q | s2_adv;
  assign in_ready = s1_adv;

  // Nonlinear (AND) and linear (XOR) terms are captured separately at the S1 boundary.
  always_comb begin
    bb     = in_sub ? ~in_b : in_b;
    v1_d   = v1_q;
    g_d    = g_q;
    p_d    = p_q;
    c0_d   = c0_q;
    tag1_d = tag1_q;
    if (s1_adv) begin
      v1_d = in_valid;
      if (in_valid) begin
        g_d    = in_a & bb;
        p_d    = in_a ^ bb;
        c0_d   = in_sub | in_cin;
        tag1_d = in_tag;
      end
    end
  end

  // Within a group the product terms are mutually exclusive, so XOR accumulation equals OR;
  // group carries ripple. Padding bits above WIDTH have g=p=0 and never affect real carries.
  always_comb begin
    gx   = PW'(g_q);
    px   = PW'(p_q);
    c    = '0;
    c[0] = c0_q;
    cg   = c0_q;
    acc  = 1'b0;
    prod = 1'b1;
    for (int gi = 0; gi < NG; gi++) begin
      for (int j = 0; j < GROUP; j++) begin
        acc  = 1'b0;
        prod = 1'b1;
        for (int k = GROUP - 1; k >= 0; k--) begin
          if (k <= j) begin
            acc  = acc ^ (prod & gx[gi*GROUP + k]);
            prod = prod & px[gi*GROUP + k];
          end
        end
        c[gi*GROUP + j + 1] = acc ^ (prod & cg);
      end
      cg = c[gi*GROUP + GROUP];
    end
  end

  always_comb begin
    ovld_d = ovld_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    tag2_d = tag2_q;
    if (s2_adv) begin
      ovld_d = v1_q;
      if (v1_q) begin
        sum_d  = p_q ^ c[WIDTH-1:0];
        cout_d = c[WIDTH];
        ovf_d  = c[WIDTH-1] ^ c[WIDTH];
        tag2_d = tag1_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      g_q    <= '0;
      p_q    <= '0;
      c0_q   <= 1'b0;
      tag1_q <= '0;
      ovld_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      tag2_q <= '0;
    end else begin
      v1_q   <= v1_d;
      g_q    <= g_d;
      p_q    <= p_d;
      c0_q   <= c0_d;
      tag1_q <= tag1_d;
      ovld_q <= ovld_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      tag2_q <= tag2_d;
    end
  end

  assign out_valid = ovld_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_tag   = tag2_q;

endmodule

// File: tb/tb_cla_decomposed_pipe.sv
// Scoreboard bench: directed checks on an 8/4 instance plus random valid/ready traffic on four configurations.
module tb_cla_decomposed_pipe;
  localparam int N = 10000;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_d, rst_n_r;

  // Reference: plain integer add/subtract, sign rules for overflow, borrow as a>=b.
  function automatic longint pack(longint sum, bit cout, bit ovf, longint tag);
    return sum | (longint'(cout) << 16) | (longint'(ovf) << 17) | (tag << 18);
  endfunction

  function automatic longint model(int w, longint a, longint b, bit cin, bit sub, longint tag);
    longint mask, full, sum;
    bit co, ov, sa, sb, ss;
    mask = (longint'(1) << w) - 1;
    if (sub) begin
      full = a - b;
      co   = (a >= b);
    end else begin
      full = a + b + longint'(cin);
      co   = ((full >> w) & 1) != 0;
    end
    sum = full & mask;
    sa  = ((a >> (w - 1)) & 1) != 0;
    sb  = ((b >> (w - 1)) & 1) != 0;
    ss  = ((sum >> (w - 1)) & 1) != 0;
    ov  = sub ? (sa != sb && ss != sa) : (sa == sb && ss != sa);
    return pack(sum, co, ov, tag);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Directed instance
  logic       d_vld, d_rdy, d_ordy, d_ovld, d_cin, d_sub, d_cout, d_ovf;
  logic [7:0] d_a, d_b, d_sum;
  logic [3:0] d_tag, d_otag;
  longint     dq[$];
  bit         hold_vld = 1'b0;
  longint     hold_key = 0;

  cla_decomposed_pipe #(.WIDTH(8), .GROUP(4), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n_d),
    .in_valid(d_vld), .in_ready(d_rdy), .in_a(d_a), .in_b(d_b),
    .in_cin(d_cin), .in_sub(d_sub), .in_tag(d_tag),
    .out_valid(d_ovld), .out_ready(d_ordy), .out_sum(d_sum),
    .out_cout(d_cout), .out_ovf(d_ovf), .out_tag(d_otag)
  );

  always @(negedge clk) begin
    longint k;
    k = pack(longint'(d_sum), d_cout, d_ovf, longint'(d_otag));
    if (d_ovld && d_ordy) begin
      if (dq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dir_unexpected: got result %0h, expected no result", k);
      end else begin
        check("dir_result", k, dq.pop_front());
      end
    end
    if (hold_vld && d_ovld) check("dir_stable", k, hold_key);
    hold_vld = d_ovld && !d_ordy;
    hold_key = k;
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic sub, input logic [3:0] tag);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    d_a = a; d_b = b; d_cin = cin; d_sub = sub; d_tag = tag; d_vld = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (d_rdy) got = 1'b1;
    end
    if (got) dq.push_back(model(8, longint'(a), longint'(b), cin, sub, longint'(tag)));
    else begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 for 100 cycles, expected acceptance");
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    d_vld = 1'b0;
  endtask

  // Random instances
  for (genvar ci = 0; ci < 4; ci++) begin : g_cfg
    localparam int W = (ci == 0) ? 8 : (ci == 1) ? 13 : (ci == 2) ? 16 : 1;
    localparam int G = (ci < 2) ? 4 : 1;
    logic         vld = 1'b0, ordy = 1'b0, cin = 1'b0, sub = 1'b0;
    logic         rdy, ovld, cout, ovf;
    logic [W-1:0] a = '0, b = '0, sum;
    logic [3:0]   tag = '0, otag;
    longint       q[$];
    int           sent = 0, rcvd = 0;
    bit           acc = 1'b0;

    cla_decomposed_pipe #(.WIDTH(W), .GROUP(G), .TAG_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n_r),
      .in_valid(vld), .in_ready(rdy), .in_a(a), .in_b(b),
      .in_cin(cin), .in_sub(sub), .in_tag(tag),
      .out_valid(ovld), .out_ready(ordy), .out_sum(sum),
      .out_cout(cout), .out_ovf(ovf), .out_tag(otag)
    );

    always @(negedge clk) begin
      if (vld && rdy) begin
        q.push_back(model(W, longint'(a), longint'(b), cin, sub, longint'(tag)));
        sent++;
        acc = 1'b1;
      end else begin
        acc = 1'b0;
      end
      if (ovld && ordy) begin
        rcvd++;
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rand%0d_extra: got unexpected result, expected none", ci);
        end else begin
          check($sformatf("rand%0d_result", ci),
                pack(longint'(sum), cout, ovf, longint'(otag)), q.pop_front());
        end
      end
    end

    initial begin
      wait (rst_n_r === 1'b1);
      for (int cyc = 0; cyc < 60000 && rcvd < N; cyc++) begin
        @(posedge clk);
        #1;
        ordy = ($urandom % 4) != 0;
        if (!vld || acc) begin
          if (sent < N && ($urandom % 4) != 0) begin
            vld = 1'b1;
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            tag = 4'($urandom);
          end else begin
            vld = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    rst_n_d = 1'b0; rst_n_r = 1'b0;
    d_vld = 1'b0; d_ordy = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0; d_tag = '0;
    #12;
    check("rst_out_valid", longint'(d_ovld), 0);
    check("rst_payload", pack(longint'(d_sum), d_cout, d_ovf, longint'(d_otag)), 0);
    check("rst_in_ready", longint'(d_rdy), 1);
    @(negedge clk);
    rst_n_d = 1'b1; rst_n_r = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", longint'(d_rdy), 1);

    // Latency: beat accepted on edge E0, out_valid seen after E1.
    @(posedge clk);
    #1;
    d_a = 8'hFF; d_b = 8'h01; d_cin = 1'b0; d_sub = 1'b0; d_tag = 4'h1; d_vld = 1'b1; d_ordy = 1'b1;
    @(negedge clk);
    check("lat_in_ready", longint'(d_rdy), 1);
    dq.push_back(model(8, 255, 1, 1'b0, 1'b0, 1));
    @(posedge clk);
    #1;
    d_vld = 1'b0;
    @(negedge clk);
    check("lat_cycle1", longint'(d_ovld), 0);
    @(negedge clk);
    check("lat_cycle2", longint'(d_ovld), 1);

    send(8'h7F, 8'h01, 1'b0, 1'b0, 4'h2);
    send(8'h05, 8'h07, 1'b0, 1'b1, 4'h3);
    send(8'h05, 8'h07, 1'b1, 1'b1, 4'h4);
    send(8'h80, 8'h01, 1'b0, 1'b1, 4'h5);
    send(8'hFF, 8'h00, 1'b1, 1'b0, 4'h6);
    idle();
    repeat (4) @(posedge clk);

    // Backpressure: six back-to-back beats, sink stalled for four cycles.
    fork
      begin
        for (int t = 0; t < 6; t++) send(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 4'(t));
        idle();
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        d_ordy = 1'b0;
        repeat (4) @(negedge clk);
        check("bp_in_ready", longint'(d_rdy), 0);
        check("bp_held_beats", longint'(dq.size()), 2);
        @(posedge clk);
        #1;
        d_ordy = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    check("bp_drained", longint'(dq.size()), 0);

    // Reset with two beats in flight.
    d_ordy = 1'b0;
    send(8'h11, 8'h22, 1'b0, 1'b0, 4'h8);
    send(8'h33, 8'h44, 1'b0, 1'b0, 4'h9);
    @(posedge clk);
    #1;
    d_vld = 1'b0;
    check("rst_pre_valid", longint'(d_ovld), 1);
    #2;
    rst_n_d = 1'b0;
    #1;
    check("rst_async_valid", longint'(d_ovld), 0);
    dq.delete();
    @(posedge clk);
    #1;
    d_ordy = 1'b1;
    @(negedge clk);
    rst_n_d = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_stale", longint'(d_ovld), 0);
    send(8'h12, 8'h34, 1'b1, 1'b0, 4'hA);
    idle();
    repeat (5) @(posedge clk);
    check("post_rst_drained", longint'(dq.size()), 0);

    for (int cyc = 0; cyc < 60000; cyc++) begin
      if (g_cfg[0].rcvd >= N && g_cfg[1].rcvd >= N && g_cfg[2].rcvd >= N && g_cfg[3].rcvd >= N)
        break;
      @(posedge clk);
    end
    check("rand0_count", longint'(g_cfg[0].rcvd), N);
    check("rand1_count", longint'(g_cfg[1].rcvd), N);
    check("rand2_count", longint'(g_cfg[2].rcvd), N);
    check("rand3_count", longint'(g_cfg[3].rcvd), N);
    check("rand0_leftover", longint'(g_cfg[0].q.size()), 0);
    check("rand3_leftover", longint'(g_cfg[3].q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
